// File: rtl/bnn_param_loader.sv
// Streams parameter bytes MSB-first into a serial neuron parameter chain.
// Each accepted byte is shifted out one bit per cycle with setup high. Only
// the first TOTAL_BITS bits of the stream are shifted; unused LSBs of the
// final byte are dropped. When the next byte is already waiting, it is
// accepted on the last shift cycle of the current byte, so there is no gap.
module bnn_param_loader #(
    parameter int unsigned NEURONS   = 4,
    parameter int unsigned INPUTS    = 8,
    parameter int unsigned BIAS_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       setup,
    output logic       param_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);
    localparam int unsigned NBYTES     = (TOTAL_BITS + 7) / 8;
    localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int unsigned BYTE_W     = $clog2(NBYTES + 1);
    localparam int unsigned LAST_BITS  = ((TOTAL_BITS % 8) == 0) ? 8 : (TOTAL_BITS % 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]         buf_q, buf_d;
    logic [3:0]         left_q, left_d;
    logic               last_q, last_d;
    logic               final_byte_c;

    // The byte about to be accepted is the final one of the stream.
    assign final_byte_c = (byte_cnt_q == BYTE_W'(NBYTES - 1));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            left_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            left_q     <= left_d;
            last_q     <= last_d;
        end
    end

    // Next-state and output decode; the byte load path is shared by FETCH and SHIFT.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        left_d     = left_q;
        last_d     = last_q;
        data_ready = 1'b0;
        setup      = 1'b0;
        param_out  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                data_ready = 1'b1;
                if (data_valid) begin
                    buf_d      = data_in;
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    last_d     = final_byte_c;
                    left_d     = final_byte_c ? 4'(LAST_BITS) : 4'd8;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                setup     = 1'b1;
                param_out = buf_q[7];
                buf_d     = {buf_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                left_d    = left_q - 4'd1;
                if (bit_cnt_q == BIT_W'(TOTAL_BITS - 1)) begin
                    state_d = DONE;
                end else if (left_q == 4'd1 && !last_q) begin
                    data_ready = 1'b1;
                    if (data_valid) begin
                        buf_d      = data_in;
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        last_d     = final_byte_c;
                        left_d     = final_byte_c ? 4'(LAST_BITS) : 4'd8;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: a small (11-bit) instance and a default (44-bit) instance.
module tb_bnn_param_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s, start_d;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready_s, setup_s, param_s, busy_s, done_s;
    logic       ready_d, setup_d, param_d, busy_d, done_d;

    always #5 clk = ~clk;

    bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .data_in(data_in),
        .data_valid(data_valid), .data_ready(ready_s), .setup(setup_s),
        .param_out(param_s), .busy(busy_s), .done(done_s)
    );

    bnn_param_loader dut_d (
        .clk(clk), .reset(reset), .start(start_d), .data_in(data_in),
        .data_valid(data_valid), .data_ready(ready_d), .setup(setup_d),
        .param_out(param_d), .busy(busy_d), .done(done_d)
    );

    // Selected instance under observation
    logic sel;
    logic ready_m, setup_m, param_m, busy_m, done_m;
    assign ready_m = sel ? ready_d : ready_s;
    assign setup_m = sel ? setup_d : setup_s;
    assign param_m = sel ? param_d : param_s;
    assign busy_m  = sel ? busy_d  : busy_s;
    assign done_m  = sel ? done_d  : done_s;

    // Neuron chain model for the default instance: first bit ends up furthest along.
    logic [43:0] chain = '0;
    always @(posedge clk) if (setup_d) chain <= {chain[42:0], param_d};

    int n_chk;
    int n_pass;
    logic exp_arr [0:63];
    int   exp_len;
    logic clr_req;
    int   setup_cnt, done_cnt, gap_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected serial stream: first 'total' bits of the byte list, MSB first.
    task automatic set_exp(input logic [7:0] b [$], input int total);
        logic [7:0] t;
        exp_len = total;
        for (int k = 0; k < total; k++) begin
            t = b[k / 8];
            exp_arr[k] = t[7 - (k % 8)];
        end
    endtask

    // Per-cycle comparison of the selected instance against the expected stream.
    task automatic monitor();
        int idx, pend;
        bit seen;
        idx = 0; pend = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (clr_req) begin
                idx = 0; pend = 0; seen = 0;
                setup_cnt = 0; done_cnt = 0; gap_cnt = 0;
            end else begin
                if (setup_m) begin
                    if (idx < exp_len) chk($sformatf("param_bit%0d", idx), 64'(param_m), 64'(exp_arr[idx]));
                    else chk("extra_setup", 64'(setup_m), 64'd0);
                    idx++;
                    setup_cnt++;
                    if (seen) gap_cnt += pend;
                    pend = 0;
                    seen = 1;
                end else begin
                    chk("param_zero_when_idle", 64'(param_m), 64'd0);
                    if (seen) pend++;
                end
                if (done_m) begin
                    done_cnt++;
                    chk("done_setup_low", 64'(setup_m), 64'd0);
                    chk("done_busy_high", 64'(busy_m), 64'd1);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        @(negedge clk);
        #1;
        clr_req = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_start();
        if (sel) start_d = 1'b1; else start_s = 1'b1;
        cyc(1);
        start_d = 1'b0;
        start_s = 1'b0;
    endtask

    // Offer bytes; byte gap_idx is withheld for 'gap' ready cycles first.
    task automatic feed(input logic [7:0] b [$], input int gap_idx, input int gap);
        for (int i = 0; i < b.size(); i++) begin
            int left;
            bit acc;
            left = (i == gap_idx) ? gap : 0;
            acc = 0;
            data_in = b[i];
            data_valid = (left == 0);
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                if (ready_m) begin
                    if (data_valid) acc = 1;
                    else left--;
                end
                @(posedge clk);
                #1;
                data_valid = acc ? 1'b0 : (left <= 0);
            end
            if (!acc) chk("feed_timeout", 64'd0, 64'd1);
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 300 && done_cnt == 0; t++) cyc(1);
        cyc(3);
    endtask

    initial begin
        logic [7:0] q_small [$];
        logic [7:0] q_def [$];
        logic [10:0] pin;
        n_chk = 0; n_pass = 0; exp_len = 0; clr_req = 1'b1;
        setup_cnt = 0; done_cnt = 0; gap_cnt = 0;
        sel = 1'b0; reset = 1'b1; start_s = 1'b0; start_d = 1'b0;
        data_in = 8'h00; data_valid = 1'b0;
        fork monitor(); join_none
        cyc(3);
        reset = 1'b0;
        clr_req = 1'b0;
        cyc(1);

        // Reset state of both instances
        chk("rst_setup", 64'({setup_s, setup_d}), 64'd0);
        chk("rst_ready", 64'({ready_s, ready_d}), 64'd0);
        chk("rst_busy",  64'({busy_s,  busy_d}),  64'd0);
        chk("rst_done",  64'({done_s,  done_d}),  64'd0);
        chk("rst_param", 64'({param_s, param_d}), 64'd0);

        // Model pin: A5,E0 over 11 bits
        q_small = '{8'hA5, 8'hE0};
        set_exp(q_small, 11);
        for (int k = 0; k < 11; k++) pin[10 - k] = exp_arr[k];
        chk("model_pin_small", 64'(pin), 64'(11'b10100101111));

        // Gapless load
        clear_mon();
        pulse_start();
        chk("busy_after_start", 64'(busy_s), 64'd1);
        feed(q_small, -1, 0);
        wait_done();
        chk("t1_setup_cnt", 64'(setup_cnt), 64'd11);
        chk("t1_gaps", 64'(gap_cnt), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_idle_busy", 64'(busy_s), 64'd0);

        // Three-cycle stall before the second byte
        clear_mon();
        pulse_start();
        feed(q_small, 1, 3);
        wait_done();
        chk("t2_setup_cnt", 64'(setup_cnt), 64'd11);
        chk("t2_gaps", 64'(gap_cnt), 64'd3);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);

        // start pulsed mid-shift is ignored
        clear_mon();
        pulse_start();
        fork
            begin
                cyc(4);
                start_s = 1'b1;
                cyc(1);
                start_s = 1'b0;
            end
        join_none
        feed(q_small, -1, 0);
        wait_done();
        cyc(5);
        chk("t3_setup_cnt", 64'(setup_cnt), 64'd11);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_busy", 64'(busy_s), 64'd0);

        // Reset after 5 bits, with start held across the reset
        clear_mon();
        pulse_start();
        data_in = 8'hA5;
        data_valid = 1'b1;
        for (int t = 0; t < 50 && setup_cnt < 4; t++) cyc(1);
        data_valid = 1'b0;
        reset = 1'b1;
        cyc(1);
        chk("t4_setup_after_rst", 64'(setup_s), 64'd0);
        chk("t4_busy_after_rst", 64'(busy_s), 64'd0);
        start_s = 1'b1;
        data_valid = 1'b1;
        cyc(1);
        reset = 1'b0;
        start_s = 1'b0;
        data_valid = 1'b0;
        chk("t4_rst_over_start", 64'(busy_s), 64'd0);
        cyc(3);
        chk("t4_bits_before_rst", 64'(setup_cnt), 64'd5);
        clear_mon();
        pulse_start();
        feed(q_small, -1, 0);
        wait_done();
        chk("t4_reload_cnt", 64'(setup_cnt), 64'd11);
        chk("t4_reload_done", 64'(done_cnt), 64'd1);

        // Default 4-neuron chain, 44 bits over 6 bytes, short stall at byte 2
        sel = 1'b1;
        q_def = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        set_exp(q_def, 44);
        clear_mon();
        pulse_start();
        feed(q_def, 2, 2);
        wait_done();
        chk("t5_setup_cnt", 64'(setup_cnt), 64'd44);
        chk("t5_gaps", 64'(gap_cnt), 64'd2);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);
        chk("t5_chain", 64'(chain), 64'(44'h123456789AB));
        chk("t5_n0_weights", 64'(chain[43:36]), 64'h12);
        chk("t5_n0_bias", 64'(chain[35:33]), 64'h1);
        chk("t5_n3_weights", 64'(chain[10:3]), 64'h35);
        chk("t5_n3_bias", 64'(chain[2:0]), 64'h3);
        chk("t5_small_quiet", 64'(busy_s), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

Interface
REQ-001 The block SHALL have parameter NEURONS, default 4: number of neurons in the serial parameter chain.
REQ-002 The block SHALL have parameter INPUTS, default 8: weight bits per neuron.
REQ-003 The block SHALL have parameter BIAS_BITS, default 3: bias bits per neuron.
REQ-004 The block SHALL derive TOTAL_BITS = NEURONS*(INPUTS+BIAS_BITS) and NBYTES = ceil(TOTAL_BITS/8).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begins a load when the block is idle.
REQ-008 The block SHALL have port data_in, input, 8 bits: parameter byte, MSB shifted first.
REQ-009 The block SHALL have port data_valid, input, 1 bit: data_in holds a valid byte.
REQ-010 The block SHALL have port data_ready, output, 1 bit: the byte is accepted on a cycle where data_valid and data_ready are both high.
REQ-011 The block SHALL have port setup, output, 1 bit: chain shift enable, driving every neuron's setup input.
REQ-012 The block SHALL have port param_out, output, 1 bit: serial bit driving the first neuron's param_in.
REQ-013 The block SHALL have port busy, output, 1 bit: high from the accepted start until done.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at load completion.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
REQ-016 In IDLE, start=1 SHALL clear the bit counter, clear the byte counter and move to FETCH; start SHALL be ignored in every other state.
REQ-017 In FETCH, data_ready SHALL be 1 and setup SHALL be 0; a handshake SHALL load data_in into an 8-bit shift buffer and move to SHIFT.
REQ-018 In SHIFT, setup SHALL be 1 and param_out SHALL equal buffer[7] every cycle; the buffer SHALL shift left by one bit per cycle.
REQ-019 The block SHALL shift exactly one chain bit per cycle with setup=1, so a neuron chain receives bits in the order they were presented.
REQ-020 Within a byte, the number of bits used SHALL be 8, except for the final byte, which SHALL use TOTAL_BITS mod 8 bits (8 if the remainder is 0); the unused LSBs of the final byte SHALL be discarded.
REQ-021 Gapless streaming: on the SHIFT cycle that emits the last used bit of a non-final byte, data_ready SHALL be 1; a handshake on that cycle SHALL reload the buffer and keep the state in SHIFT with no setup gap.
REQ-022 If no byte is accepted on the cycle of REQ-021, the FSM SHALL go to FETCH, and setup SHALL be 0 (stall) until a byte arrives.
REQ-023 After the cycle emitting bit TOTAL_BITS, the FSM SHALL enter DONE for exactly one cycle with done=1 and setup=0, then return to IDLE.
REQ-024 data_ready SHALL be 0 in IDLE, in DONE, and while shifting the final byte.
REQ-025 busy SHALL be 1 in FETCH, SHIFT and DONE.
REQ-026 The total cycles with setup=1 per load SHALL equal TOTAL_BITS exactly, regardless of stalls.
REQ-027 The bit counter SHALL be $clog2(TOTAL_BITS+1) bits wide and SHALL never wrap within a load.
REQ-028 When setup=0, param_out SHALL be 0.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL go to IDLE, the counters and buffer SHALL clear, and setup, param_out, data_ready, busy and done SHALL be 0 on the next cycle.
REQ-030 Reset SHALL override start and data_valid in the same cycle.
REQ-031 Reset mid-load SHALL abort immediately with no further setup cycles; a partially shifted chain SHALL be left as is.
REQ-032 A new start after reset SHALL perform a complete load from bit 0.

Verification
REQ-033 NEURONS=1, INPUTS=8, BIAS_BITS=3; start, then bytes 0xA5 and 0xE0 with data_valid always high -> 11 consecutive setup cycles with param_out 1,0,1,0,0,1,0,1,1,1,1, then done for one cycle, then IDLE.
REQ-034 Same configuration; data_valid dropped for 3 cycles after the first byte -> setup low for 3 cycles in FETCH, 11 setup cycles in total, same bit sequence.
REQ-035 Defaults (44 bits, 6 bytes); a 4-neuron chain loaded with a pattern, then the chain's inputs applied -> each neuron's weights/bias match the pattern, and the last byte's low 4 bits are ignored.
REQ-036 start pulsed during SHIFT -> no effect; exactly one done pulse.
REQ-037 reset asserted after 5 shifted bits -> the next cycle has setup=0 and busy=0; a following start reloads all bits correctly.
